posit_mult_raw_pipe_es3: RTL and testbench
==========================================

Name: posit_mult_raw_pipe_es3

Overview:
- Parametrised raw-domain posit multiplier for the ES3 arithmetic path.
- Multiplies a serialized sum-format value A (wide accumulator fraction) by a serialized value B. Emits an unrounded serialized product for the downstream normaliser/accumulator.
- Generalised over scale/fraction widths and pipeline depth. Adds a valid/ready handshake with per-stage backpressure and bubble collapsing, plus a tag sideband.
- Widens the product scale by one bit so that scale overflow cannot occur.

Parameters:
- SW, 9, scale width of A and B (two's complement)
- AW, 30, fraction width of A (hidden bit excluded)
- FW, 26, fraction width of B; also the number of A fraction MSBs used (AW >= FW required)
- LATENCY, 4, register stages from input to output (>= 2)
- TAGW, 8, sideband tag width, passed through unchanged
- Derived: MW = 2*FW+2; IN_A_W = SW+AW+3; IN_B_W = SW+FW+3; OUT_W = SW+MW+4

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept a beat
- in_a  in  IN_A_W  {sgn, scale[SW-1:0], fraction[AW-1:0], inf, zero}
- in_b  in  IN_B_W  {sgn, scale[SW-1:0], fraction[FW-1:0], inf, zero}
- in_tag  in  TAGW  sideband
- out_valid  out  1  product valid
- out_ready  in  1  downstream accepts
- out_product  out  OUT_W  {sgn, scale[SW:0], fraction[MW-1:0], inf, zero}
- out_tag  out  TAGW  tag of this product

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - all stage valid bits clear; out_valid=0, out_product=0, out_tag=0.
  - in_ready=1 after reset.
  - Reset mid-operation discards all in-flight beats; no partial output.
- Handshake:
  - Beat transfers on an edge when valid&ready.
  - Stage i loads when its valid is 0 or stage i+1 loads; the last stage loads when its valid is 0 or out_ready=1.
  - in_ready = stage-0 load condition. Bubbles collapse.
  - Capacity: LATENCY beats. Ordering is strict FIFO.
  - out_product and out_tag are held stable while out_valid=1 and out_ready=0.
- Latency: beat accepted at edge t gives out_valid=1 after edge t+LATENCY-1, i.e. on the LATENCY-th edge counting the accept edge, with no stall.
- Stage 0 (input register):
  - Operand with zero=1: sgn, scale, fraction and inf are cleared, zero=1 kept.
  - B fraction is left-aligned to AW bits with zero fill.
- Stage 1 (arithmetic):
  - ma = {1, a.fraction[AW-1 -: FW]}; mb = {1, b.fraction}; p = ma*mb, unsigned, MW bits.
  - Scale sum is sign-extended to SW+1 bits: s = a.scale + b.scale.
  - If p[MW-1]=1: scale = s+1, fraction = p<<1. Otherwise scale = s, fraction = p<<2 (hidden bit shifted out, MW bits kept).
  - sgn = a.sgn ^ b.sgn.
  - inf = a.inf | b.inf.
  - zero = ~inf & (a.zero | b.zero).
  - If inf or zero: sgn, scale and fraction are forced to 0.
- Stages 2..LATENCY-1: pure pipeline registers with the same load rule.
- Scale range: SW+1 bits hold every sum of two SW-bit scales +1, so no wrap.
- Simultaneous out_ready=1 and in_valid=1 with a full pipe: in_ready=1 in the same cycle, and the pipe advances without a bubble.

Test Plan:
- Defaults. a = {0, scale 2, frac 0x2000_0000}, b = {0, scale 3, frac 0x200_0000} (1.5×1.5) -> out sgn 0, scale 6, fraction 0x0008_0000_0000_0000, inf 0, zero 0; out_valid 4 cycles after accept.
- a = 1.0 with scale -4, b = -1.0 with scale 3 (all fraction bits 0) -> sgn 1, scale -1 (10-bit 0x3FF), fraction 0.
- Scale extremes. a.scale = 255, b.scale = 255, both fractions 1.5 -> scale 511, no wrap. a.scale = -256, b.scale = -256 with 1.0×1.0 -> scale -512 (0x200).
- Specials:
  - a.zero=1, b finite -> zero 1, all other fields 0.
  - a.zero=1, b.inf=1 -> inf 1, zero 0, fields 0.
- Backpressure. out_ready=0; push 5 beats with tags 1..5 -> 4 accepted, in_ready=0 on the 5th, output held at tag 1. Raise out_ready -> tags 1..5 emerge back-to-back in order.
- Reset mid-flight. Assert rst_n=0 asynchronously with 3 beats in flight -> out_valid=0 immediately, in_ready=1 after release, no stale beat emerges.

Source files
------------

// File: rtl/posit_mult_raw_pipe_es3.sv
// rtl/posit_mult_raw_pipe_es3.sv - raw-domain posit multiplier (sum-format A x B), elastic pipeline with tag sideband
// Product scale is one bit wider than the operand scales, so scale overflow cannot occur.
module posit_mult_raw_pipe_es3 #(
  parameter int SW      = 9,
  parameter int AW      = 30,
  parameter int FW      = 26,
  parameter int LATENCY = 4,
  parameter int TAGW    = 8,
  localparam int MW     = 2*FW+2,
  localparam int IN_A_W = SW+AW+3,
  localparam int IN_B_W = SW+FW+3,
  localparam int OUT_W  = SW+MW+4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IN_A_W-1:0] in_a,
  input  logic [IN_B_W-1:0] in_b,
  input  logic [TAGW-1:0]   in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_product,
  output logic [TAGW-1:0]   out_tag
);

  // Operand field extraction
  logic          a_sgn, a_inf, a_zero;
  logic [SW-1:0] a_scale;
  logic [FW-1:0] a_frac_msb;
  logic          b_sgn, b_inf, b_zero;
  logic [SW-1:0] b_scale;
  logic [FW-1:0] b_frac;

  assign a_sgn      = in_a[IN_A_W-1];
  assign a_scale    = in_a[IN_A_W-2 -: SW];
  assign a_frac_msb = in_a[AW+1 -: FW];
  assign a_inf      = in_a[1];
  assign a_zero     = in_a[0];

  assign b_sgn      = in_b[IN_B_W-1];
  assign b_scale    = in_b[IN_B_W-2 -: SW];
  assign b_frac     = in_b[FW+1 -: FW];
  assign b_inf      = in_b[1];
  assign b_zero     = in_b[0];

  // Only the top FW bits of A's fraction take part in the product.
  generate
    if (AW > FW) begin : g_a_lsbs
      logic unused_a_lsbs;
      assign unused_a_lsbs = ^in_a[AW-FW+1:2];
    end
  endgenerate

  // Stage-0 next state: a zero operand has every other field cleared.
  logic          a_sgn_d, a_inf_d, b_sgn_d, b_inf_d;
  logic [SW-1:0] a_scale_d, b_scale_d;
  logic [FW-1:0] a_frac_d, b_frac_d;

  always_comb begin
    a_sgn_d   = a_sgn & ~a_zero;
    a_inf_d   = a_inf & ~a_zero;
    a_scale_d = a_zero ? '0 : a_scale;
    a_frac_d  = a_zero ? '0 : a_frac_msb;
    b_sgn_d   = b_sgn & ~b_zero;
    b_inf_d   = b_inf & ~b_zero;
    b_scale_d = b_zero ? '0 : b_scale;
    b_frac_d  = b_zero ? '0 : b_frac;
  end

  // Stage-0 registers (B is kept at its FW MSBs; the AW-aligned zero fill carries no information)
  logic          a_sgn_q, a_inf_q, a_zero_q, b_sgn_q, b_inf_q, b_zero_q;
  logic [SW-1:0] a_scale_q, b_scale_q;
  logic [FW-1:0] a_frac_q, b_frac_q;
  logic [TAGW-1:0] s0_tag_q;

  // Stage valids, load enables and product stages 1..LATENCY-1
  logic [LATENCY-1:0]              vld_q;
  logic [LATENCY-1:0]              ld;
  logic [LATENCY-1:1][OUT_W-1:0]   prod_q;
  logic [LATENCY-1:1][TAGW-1:0]    tag_q;
  logic [OUT_W-1:0]                prod_d;

  // A stage loads when it or any stage downstream of it is empty, or the sink accepts.
  generate
    for (genvar i = 0; i < LATENCY; i++) begin : g_ld
      assign ld[i] = out_ready | ~(&vld_q[LATENCY-1:i]);
    end
  endgenerate

  // Stage-1 arithmetic
  logic [FW:0]   ma, mb;
  logic [MW-1:0] p;
  logic [SW:0]   s_sum, s_out;
  logic [MW-1:0] f_out;
  logic          sgn_out, inf_out, zero_out;

  always_comb begin
    ma       = {1'b1, a_frac_q};
    mb       = {1'b1, b_frac_q};
    p        = {{(FW+1){1'b0}}, ma} * {{(FW+1){1'b0}}, mb};
    s_sum    = {a_scale_q[SW-1], a_scale_q} + {b_scale_q[SW-1], b_scale_q};
    inf_out  = a_inf_q | b_inf_q;
    zero_out = ~inf_out & (a_zero_q | b_zero_q);
    sgn_out  = a_sgn_q ^ b_sgn_q;
    // Product mantissa lies in [1,4): drop the hidden bit from whichever position it sits in.
    if (p[MW-1]) begin
      s_out = s_sum + {{SW{1'b0}}, 1'b1};
      f_out = {p[MW-2:0], 1'b0};
    end else begin
      s_out = s_sum;
      f_out = {p[MW-3:0], 2'b00};
    end
    if (inf_out | zero_out) begin
      sgn_out = 1'b0;
      s_out   = '0;
      f_out   = '0;
    end
    prod_d = {sgn_out, s_out, f_out, inf_out, zero_out};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q     <= '0;
      a_sgn_q   <= 1'b0;
      a_inf_q   <= 1'b0;
      a_zero_q  <= 1'b0;
      a_scale_q <= '0;
      a_frac_q  <= '0;
      b_sgn_q   <= 1'b0;
      b_inf_q   <= 1'b0;
      b_zero_q  <= 1'b0;
      b_scale_q <= '0;
      b_frac_q  <= '0;
      s0_tag_q  <= '0;
      prod_q    <= '0;
      tag_q     <= '0;
    end else begin
      if (ld[0]) begin
        vld_q[0] <= in_valid;
        if (in_valid) begin
          a_sgn_q   <= a_sgn_d;
          a_inf_q   <= a_inf_d;
          a_zero_q  <= a_zero;
          a_scale_q <= a_scale_d;
          a_frac_q  <= a_frac_d;
          b_sgn_q   <= b_sgn_d;
          b_inf_q   <= b_inf_d;
          b_zero_q  <= b_zero;
          b_scale_q <= b_scale_d;
          b_frac_q  <= b_frac_d;
          s0_tag_q  <= in_tag;
        end
      end
      if (ld[1]) begin
        vld_q[1] <= vld_q[0];
        if (vld_q[0]) begin
          prod_q[1] <= prod_d;
          tag_q[1]  <= s0_tag_q;
        end
      end
      for (int i = 2; i < LATENCY; i++) begin
        if (ld[i]) begin
          vld_q[i] <= vld_q[i-1];
          if (vld_q[i-1]) begin
            prod_q[i] <= prod_q[i-1];
            tag_q[i]  <= tag_q[i-1];
          end
        end
      end
    end
  end

  assign in_ready    = ld[0];
  assign out_valid   = vld_q[LATENCY-1];
  assign out_product = prod_q[LATENCY-1];
  assign out_tag     = tag_q[LATENCY-1];

endmodule

// File: tb/tb_posit_mult_raw_pipe_es3.sv
// tb/tb_posit_mult_raw_pipe_es3.sv - scoreboard bench for posit_mult_raw_pipe_es3
module tb_posit_mult_raw_pipe_es3;

  localparam int OUT_W = 67;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [41:0] in_a = '0;
  logic [37:0] in_b = '0;
  logic [7:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [66:0] out_product;
  logic [7:0]  out_tag;

  posit_mult_raw_pipe_es3 #(.SW(9), .AW(30), .FW(26), .LATENCY(4), .TAGW(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_product(out_product), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [66:0] prod; logic [7:0] tag; } exp_t;
  exp_t sb_q[$];
  logic [7:0] tag_hist[$];
  int         cyc_hist[$];
  int n_checks = 0, n_fail = 0, out_cnt = 0, cyc = 0;
  logic [66:0] last_prod = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [41:0] mk_a(logic s, logic [8:0] sc, logic [29:0] f, logic inf, logic z);
    return {s, sc, f, inf, z};
  endfunction

  function automatic logic [37:0] mk_b(logic s, logic [8:0] sc, logic [25:0] f, logic inf, logic z);
    return {s, sc, f, inf, z};
  endfunction

  // Reference: value-level multiply on 64-bit integers.
  function automatic logic [66:0] model(logic [41:0] a, logic [37:0] b);
    logic as, bs, ai, bi, az, bz, sg, inf, zero;
    logic [8:0] asc, bsc;
    logic [29:0] af;
    logic [25:0] bf;
    longint unsigned ma, mb, m, fr;
    int sc;
    {as, asc, af, ai, az} = a;
    {bs, bsc, bf, bi, bz} = b;
    if (az) begin as = 0; asc = 0; af = 0; ai = 0; end
    if (bz) begin bs = 0; bsc = 0; bf = 0; bi = 0; end
    inf  = ai | bi;
    zero = !inf && (az || bz);
    if (inf || zero) return {1'b0, 10'd0, 54'd0, inf, zero};
    sg = as ^ bs;
    sc = int'($signed(asc)) + int'($signed(bsc));
    ma = (64'd1 << 26) + 64'(af[29:4]);
    mb = (64'd1 << 26) + 64'(bf);
    m  = ma * mb;
    if (m >= (64'd1 << 53)) begin
      sc = sc + 1;
      fr = (m - (64'd1 << 53)) * 2;
    end else begin
      fr = (m - (64'd1 << 52)) * 4;
    end
    return {sg, 10'(sc), fr[53:0], 2'b00};
  endfunction

  // Monitor: push on input transfer, pop/compare on output transfer.
  always @(negedge clk) begin
    if (rst_n) begin
      if (in_valid && in_ready) sb_q.push_back({model(in_a, in_b), in_tag});
      if (out_valid && out_ready) begin
        exp_t e;
        out_cnt++;
        last_prod = out_product;
        tag_hist.push_back(out_tag);
        cyc_hist.push_back(cyc);
        if (sb_q.size() == 0) check("sb_unexpected_output", 1, 0);
        else begin
          e = sb_q.pop_front();
          check("sb_product", out_product, e.prod);
          check("sb_tag", out_tag, e.tag);
        end
      end
    end
  end

  task automatic send(input logic [41:0] a, input logic [37:0] b, input logic [7:0] t);
    bit ok = 0;
    in_a = a; in_b = b; in_tag = t; in_valid = 1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    if (!ok) check("send_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  task automatic run_one(input string name, input logic [41:0] a, input logic [37:0] b,
                         input logic [66:0] exp, input bit do_lat);
    int c0 = out_cnt;
    int n = 1;
    out_ready = 1;
    send(a, b, 8'hA5);
    while (n <= 20) begin
      @(negedge clk);
      if (out_valid) break;
      @(posedge clk); #1;
      n++;
    end
    if (do_lat) check("latency", n, 4);
    @(posedge clk); #1;
    check({name, "_count"}, out_cnt, c0 + 1);
    check(name, last_prod, exp);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [41:0] a1;
    logic [37:0] b1;
    logic [66:0] e1;
    int acc_n, h0, c0, sent;
    bit acc;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_product", out_product, 0);
    check("rst_out_tag", out_tag, 0);
    check("rst_in_ready", in_ready, 1);
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;

    // Directed arithmetic and boundary cases
    run_one("d_1p5x1p5", mk_a(0, 9'd2, 30'h2000_0000, 0, 0), mk_b(0, 9'd3, 26'h200_0000, 0, 0),
            {1'b0, 10'd6, 54'h0008_0000_0000_0000, 2'b00}, 1);
    run_one("d_neg_one", mk_a(0, 9'h1FC, 30'h0, 0, 0), mk_b(1, 9'd3, 26'h0, 0, 0),
            {1'b1, 10'h3FF, 54'h0, 2'b00}, 0);
    run_one("d_scale_max", mk_a(0, 9'd255, 30'h2000_0000, 0, 0), mk_b(0, 9'd255, 26'h200_0000, 0, 0),
            {1'b0, 10'h1FF, 54'h0008_0000_0000_0000, 2'b00}, 0);
    run_one("d_scale_min", mk_a(0, 9'h100, 30'h0, 0, 0), mk_b(0, 9'h100, 26'h0, 0, 0),
            {1'b0, 10'h200, 54'h0, 2'b00}, 0);
    run_one("d_zero", mk_a(1, 9'd5, 30'h1234_5678, 0, 1), mk_b(1, 9'd7, 26'h155_5555, 0, 0),
            67'h1, 0);
    run_one("d_zero_inf", mk_a(1, 9'd5, 30'h1234_5678, 0, 1), mk_b(0, 9'd7, 26'h155_5555, 1, 0),
            67'h2, 0);

    // Randomised traffic with random backpressure
    sent = 0;
    in_valid = 0;
    for (int cy = 0; cy < 3000 && (sent < 40 || sb_q.size() != 0); cy++) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) begin sent++; in_valid = 0; end
      if (!in_valid && sent < 40 && $urandom_range(0, 3) != 0) begin
        in_a = mk_a(1'($urandom), 9'($urandom), 30'($urandom), $urandom_range(0, 14) == 0, $urandom_range(0, 9) == 0);
        in_b = mk_b(1'($urandom), 9'($urandom), 26'($urandom), $urandom_range(0, 14) == 0, $urandom_range(0, 9) == 0);
        in_tag = 8'(sent);
        in_valid = 1;
      end
      out_ready = ($urandom_range(0, 3) != 0);
    end
    out_ready = 1;
    check("rand_sent", sent, 40);
    check("rand_drained", sb_q.size(), 0);
    repeat (2) @(posedge clk);
    #1;

    // Backpressure: capacity, hold, back-to-back release
    out_ready = 0;
    acc_n = 0;
    a1 = mk_a(0, 9'd1, 30'h3000_0000, 0, 0);
    b1 = mk_b(1, 9'd2, 26'h300_0000, 0, 0);
    e1 = model(a1, b1);
    for (int k = 1; k <= 5; k++) begin
      in_a = (k == 1) ? a1 : mk_a(0, 9'(k), 30'(k * 30'h0111_1111), 0, 0);
      in_b = (k == 1) ? b1 : mk_b(1, 9'(k), 26'(k * 26'h011_1111), 0, 0);
      in_tag = 8'(k);
      in_valid = 1;
      @(negedge clk);
      if (!in_ready) break;
      @(posedge clk); #1;
      acc_n++;
    end
    check("bp_accepted", acc_n, 4);
    check("bp_in_ready_full", in_ready, 0);
    check("bp_out_valid", out_valid, 1);
    check("bp_head_tag", out_tag, 1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("bp_hold_tag", out_tag, 1);
    check("bp_hold_product", out_product, e1);
    check("bp_hold_in_ready", in_ready, 0);
    @(posedge clk); #1;
    h0 = tag_hist.size();
    out_ready = 1;
    @(negedge clk);
    check("bp_in_ready_release", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 0;
    repeat (8) @(posedge clk);
    #1;
    check("bp_emerged", tag_hist.size() - h0, 5);
    if (tag_hist.size() >= h0 + 5) begin
      for (int i = 0; i < 5; i++) begin
        check("bp_order", tag_hist[h0 + i], i + 1);
        check("bp_back_to_back", cyc_hist[h0 + i] - cyc_hist[h0], i);
      end
    end

    // Reset with beats in flight
    out_ready = 0;
    send(mk_a(0, 9'd9, 30'h0AAA_AAAA, 0, 0), mk_b(0, 9'd1, 26'h0AA_AAAA, 0, 0), 8'h31);
    send(mk_a(1, 9'd8, 30'h1555_5555, 0, 0), mk_b(0, 9'd2, 26'h155_5555, 0, 0), 8'h32);
    send(mk_a(0, 9'd7, 30'h0F0F_0F0F, 0, 0), mk_b(1, 9'd3, 26'h0F0_F0F0, 0, 0), 8'h33);
    @(posedge clk); #1;
    check("rst_pre_out_valid", out_valid, 1);
    #2;
    rst_n = 0;
    #1;
    check("rst_mid_out_valid", out_valid, 0);
    check("rst_mid_out_product", out_product, 0);
    check("rst_mid_out_tag", out_tag, 0);
    check("rst_mid_in_ready", in_ready, 1);
    sb_q.delete();
    c0 = out_cnt;
    @(negedge clk);
    rst_n = 1;
    out_ready = 1;
    @(posedge clk); #1;
    check("rst_post_in_ready", in_ready, 1);
    repeat (10) @(posedge clk);
    #1;
    check("rst_no_stale", out_cnt, c0);
    check("rst_post_out_valid", out_valid, 0);

    check("sb_final_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
